ch_measure_ctrl: RTL and testbench
==================================

Name: ch_measure_ctrl

Overview:
Single-clock controller for equivalent-time waveform capture on one channel.
- For each delay-line code it ramps a DAC threshold and fires a strobe per step through an external strobe generator.
- It samples the latched comparator after each strobe and finds where the signal falls below the threshold.
- It emits one (time, voltage) point per delay code.
- It sits between the DAC, the comparator, the delay line and the strobe generator (stb_gen, separate clock domain).

Parameters:
- V_W, 16, threshold/voltage width
- T_W, 10, delay-code width
- SYNC_STAGES, 2, flops per input synchronizer
- CMP_SETTLE, 2, clk cycles to wait after stb_valid before sampling the comparator

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous active-low reset
- run_i  in  1  start/continue sweep (level)
- threshold_delta_i  in  V_W  threshold step per strobe
- d_code_delta_i  in  T_W  delay-code step per point
- threshold_o  out  V_W  DAC code
- threshold_wre_o  out  1  DAC write strobe, one-cycle pulse
- threshold_rdy_i  in  1  DAC settled (async)
- cmp_out_i  in  1  latched comparator, 1 = signal >= threshold (async)
- stb_req_o  out  1  strobe request to stb_gen
- stb_valid_i  in  1  strobe issued, from hclk domain (async)
- d_code_o  out  T_W  delay-line code
- point_rdy_o  out  1  one-cycle pulse, point valid
- point_v_o  out  V_W  measured voltage code
- point_t_o  out  T_W  delay code of that point

Behaviour:
- Synchronizers: threshold_rdy_i, cmp_out_i and stb_valid_i each pass through a SYNC_STAGES synchronizer before use.
- Reset values: all outputs 0; FSM in IDLE.
- IDLE:
  - d_code_o = 0, threshold_o = 0.
  - On run_i=1, go to SET_THR.
- SET_THR: drive threshold_o; pulse threshold_wre_o for 1 cycle; go to WAIT_RDY_LO.
- WAIT_RDY_LO: wait until synced rdy = 0, then go to WAIT_RDY_HI.
- WAIT_RDY_HI: wait until synced rdy = 1, then go to STB_REQ.
- STB_REQ: four-phase handshake.
  - Assert stb_req_o and hold it until synced stb_valid = 1.
  - Then wait CMP_SETTLE cycles and sample synced cmp_out.
  - Deassert stb_req_o; wait synced stb_valid = 0; go to EVAL.
- EVAL:
  - cmp=1 and threshold + delta fits in V_W bits (17-bit sum, no carry): record last_v = threshold_o, threshold_o += delta, go to SET_THR.
  - cmp=1 and the sum overflows: point_v = all-ones (saturate), go to EMIT.
  - cmp=0: point_v = last_v (0 if the first step already failed), go to EMIT.
- EMIT:
  - point_v_o and point_t_o = d_code_o, stable from this cycle until the next EMIT; point_rdy_o = 1 for exactly 1 cycle.
  - Then go to NEXT.
- NEXT:
  - d_code + d_code_delta_i computed in T_W+1 bits; if it exceeds 2^T_W - 1, go to DONE.
  - Otherwise d_code_o updates, threshold_o = 0, last_v = 0, go to SET_THR.
  - d_code_o changes only in NEXT or IDLE.
- DONE: hold outputs and issue no requests; return to IDLE when run_i = 0.
- run_i deasserted in any busy state: abort to IDLE next cycle with wre and req deasserted; no point emitted.
- Delta of 0 for either step is treated as 1.
- Inputs threshold_delta_i and d_code_delta_i are sampled at each use.

Decomposition:
- Package ch_measure_pkg: state enum (IDLE, SET_THR, WAIT_RDY_LO, WAIT_RDY_HI, STB_REQ, STB_SETTLE, STB_REL, EVAL, EMIT, NEXT, DONE) and the width constants V_W and T_W.
- One sub-module: sync_ff, a generic N-stage synchronizer with async active-low reset, instantiated three times.

Test Plan:
- Reset mid-sweep (arst_i low 1 cycle): all outputs 0, state IDLE, stb_req_o = 0 immediately.
- Signal static at 100, threshold_delta_i = 1, d_code_delta_i = 1 → point_v_o = 100 for every point; point_t_o runs 0..1023; exactly 1024 point_rdy_o pulses, then DONE.
- Sine 10..265 at 5 MHz through stb_gen, DAC ready delay 200 ns, clk 25 MHz → point_v_o follows the sine sampled at d_code ns; the final point has point_t_o = 1023.
- threshold_delta_i = 16, static signal at 100 → point_v_o = 96; each point uses 8 DAC writes.
- Signal always above any threshold → threshold saturates, point_v_o = 16'hFFFF.
- d_code_delta_i = 300 → points at t = 0, 300, 600, 900, then DONE; dropping run_i mid-point → IDLE with no pulse on point_rdy_o.

Source files
------------

// File: rtl/ch_measure_pkg.sv
// Shared types and widths for the equivalent-time channel measurement controller.
package ch_measure_pkg;

  localparam int unsigned V_W = 16;
  localparam int unsigned T_W = 10;

  typedef enum logic [3:0] {
    IDLE,
    SET_THR,
    WAIT_RDY_LO,
    WAIT_RDY_HI,
    STB_REQ,
    STB_SETTLE,
    STB_REL,
    EVAL,
    EMIT,
    NEXT,
    DONE
  } state_e;

  // One captured waveform point: voltage code and the delay code it was taken at.
  typedef struct packed {
    logic [V_W-1:0] v;
    logic [T_W-1:0] t;
  } point_t;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous bit; STAGES must be >= 2.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ch_measure_ctrl.sv
// Threshold-ramp controller: per delay code, ramps the DAC and strobes the comparator
// until the signal drops below the threshold, then emits one (time, voltage) point.
module ch_measure_ctrl
  import ch_measure_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CMP_SETTLE  = 2
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           run_i,
  input  logic [V_W-1:0] threshold_delta_i,
  input  logic [T_W-1:0] d_code_delta_i,
  output logic [V_W-1:0] threshold_o,
  output logic           threshold_wre_o,
  input  logic           threshold_rdy_i,
  input  logic           cmp_out_i,
  output logic           stb_req_o,
  input  logic           stb_valid_i,
  output logic [T_W-1:0] d_code_o,
  output logic           point_rdy_o,
  output logic [V_W-1:0] point_v_o,
  output logic [T_W-1:0] point_t_o
);

  localparam int unsigned CNT_W = (CMP_SETTLE > 1) ? $clog2(CMP_SETTLE) : 1;

  logic rdy_s, cmp_s, valid_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk_i(clk_i), .arst_i(arst_i), .d_i(threshold_rdy_i), .q_o(rdy_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cmp (
    .clk_i(clk_i), .arst_i(arst_i), .d_i(cmp_out_i), .q_o(cmp_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_vld (
    .clk_i(clk_i), .arst_i(arst_i), .d_i(stb_valid_i), .q_o(valid_s));

  state_e         state_q, state_d;
  logic [V_W-1:0] thr_q, thr_d;
  logic [V_W-1:0] last_v_q, last_v_d;
  logic [T_W-1:0] d_code_q, d_code_d;
  logic           cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  point_t         pt_q, pt_d;
  logic           wre_q, wre_d;
  logic           req_q, req_d;
  logic           prdy_q, prdy_d;

  logic [V_W-1:0] thr_step;
  logic [T_W-1:0] code_step;
  logic [V_W:0]   thr_sum;
  logic [T_W:0]   code_sum;
  logic           busy;

  // Step sizes (zero treated as one) and carry-extended sums for overflow detection.
  always_comb begin
    thr_step  = (threshold_delta_i == '0) ? V_W'(1) : threshold_delta_i;
    code_step = (d_code_delta_i == '0) ? T_W'(1) : d_code_delta_i;
    thr_sum   = {1'b0, thr_q} + {1'b0, thr_step};
    code_sum  = {1'b0, d_code_q} + {1'b0, code_step};
    busy      = (state_q != IDLE) && (state_q != DONE);
  end

  // Next-state and datapath updates; dropping run_i while busy aborts to IDLE.
  always_comb begin
    state_d  = state_q;
    thr_d    = thr_q;
    last_v_d = last_v_q;
    d_code_d = d_code_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    pt_d     = pt_q;

    if (busy && !run_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          thr_d    = '0;
          last_v_d = '0;
          d_code_d = '0;
          if (run_i) state_d = SET_THR;
        end
        SET_THR:     state_d = WAIT_RDY_LO;
        WAIT_RDY_LO: if (!rdy_s) state_d = WAIT_RDY_HI;
        WAIT_RDY_HI: if (rdy_s) state_d = STB_REQ;
        STB_REQ: begin
          if (valid_s) begin
            cnt_d   = '0;
            state_d = STB_SETTLE;
          end
        end
        STB_SETTLE: begin
          if (cnt_q == CNT_W'(CMP_SETTLE - 1)) begin
            cmp_d   = cmp_s;
            state_d = STB_REL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STB_REL: if (!valid_s) state_d = EVAL;
        EVAL: begin
          pt_d.t = d_code_q;
          if (cmp_q && !thr_sum[V_W]) begin
            last_v_d = thr_q;
            thr_d    = thr_sum[V_W-1:0];
            state_d  = SET_THR;
          end else if (cmp_q) begin
            pt_d.v  = '1;
            state_d = EMIT;
          end else begin
            pt_d.v  = last_v_q;
            state_d = EMIT;
          end
          if (state_d != EMIT) pt_d = pt_q;
        end
        EMIT: state_d = NEXT;
        NEXT: begin
          if (code_sum[T_W]) begin
            state_d = DONE;
          end else begin
            d_code_d = code_sum[T_W-1:0];
            thr_d    = '0;
            last_v_d = '0;
            state_d  = SET_THR;
          end
        end
        DONE:    if (!run_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    wre_d  = (state_q == SET_THR) && (state_d == WAIT_RDY_LO);
    req_d  = (state_d == STB_REQ) || (state_d == STB_SETTLE);
    prdy_d = (state_d == EMIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q  <= IDLE;
      thr_q    <= '0;
      last_v_q <= '0;
      d_code_q <= '0;
      cmp_q    <= 1'b0;
      cnt_q    <= '0;
      pt_q     <= '0;
      wre_q    <= 1'b0;
      req_q    <= 1'b0;
      prdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      last_v_q <= last_v_d;
      d_code_q <= d_code_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      pt_q     <= pt_d;
      wre_q    <= wre_d;
      req_q    <= req_d;
      prdy_q   <= prdy_d;
    end
  end

  assign threshold_o     = thr_q;
  assign threshold_wre_o = wre_q;
  assign stb_req_o       = req_q;
  assign d_code_o        = d_code_q;
  assign point_rdy_o     = prdy_q;
  assign point_v_o       = pt_q.v;
  assign point_t_o       = pt_q.t;

endmodule

// File: tb/tb_ch_measure_ctrl.sv
// Directed bench for ch_measure_ctrl with a DAC / strobe-generator / comparator model.
module tb_ch_measure_ctrl;
  import ch_measure_pkg::*;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic           run = 1'b0;
  logic [V_W-1:0] tdelta = V_W'(1);
  logic [T_W-1:0] ddelta = T_W'(1);
  logic           rdy = 1'b1;
  logic           valid = 1'b0;
  logic           cmp;
  logic [V_W-1:0] sig_v = V_W'(100);
  logic           always_hi = 1'b0;

  logic [V_W-1:0] threshold_o;
  logic           threshold_wre_o;
  logic           stb_req_o;
  logic [T_W-1:0] d_code_o;
  logic           point_rdy_o;
  logic [V_W-1:0] point_v_o;
  logic [T_W-1:0] point_t_o;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int wre_cnt = 0;
  int wide_cnt = 0;
  logic prev_prdy = 1'b0;
  logic [V_W-1:0] v_q[$];
  logic [T_W-1:0] t_q[$];
  int w_q[$];

  ch_measure_ctrl dut (
    .clk_i            (clk),
    .arst_i           (arst),
    .run_i            (run),
    .threshold_delta_i(tdelta),
    .d_code_delta_i   (ddelta),
    .threshold_o      (threshold_o),
    .threshold_wre_o  (threshold_wre_o),
    .threshold_rdy_i  (rdy),
    .cmp_out_i        (cmp),
    .stb_req_o        (stb_req_o),
    .stb_valid_i      (valid),
    .d_code_o         (d_code_o),
    .point_rdy_o      (point_rdy_o),
    .point_v_o        (point_v_o),
    .point_t_o        (point_t_o)
  );

  always #5 clk = ~clk;

  // Comparator: 1 while the static signal is at or above the DAC threshold.
  assign cmp = always_hi | (threshold_o <= sig_v);

  // DAC settle model, strobe generator echo, and point/write capture.
  always @(negedge clk) begin
    if (!arst) begin
      rdy       <= 1'b1;
      valid     <= 1'b0;
      rdy_cnt   <= 0;
      prev_prdy <= 1'b0;
      wre_cnt   <= 0;
    end else begin
      if (threshold_wre_o) begin
        rdy     <= 1'b0;
        rdy_cnt <= 3;
      end else if (rdy_cnt > 0) begin
        rdy_cnt <= rdy_cnt - 1;
        if (rdy_cnt == 1) rdy <= 1'b1;
      end
      valid <= stb_req_o;
      if (point_rdy_o) begin
        if (prev_prdy) wide_cnt <= wide_cnt + 1;
        v_q.push_back(point_v_o);
        t_q.push_back(point_t_o);
        w_q.push_back(wre_cnt);
        wre_cnt <= 0;
      end else if (!run) begin
        wre_cnt <= 0;
      end else if (threshold_wre_o) begin
        wre_cnt <= wre_cnt + 1;
      end
      prev_prdy <= point_rdy_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [V_W-1:0] sv, input logic hi,
                       input logic [V_W-1:0] td, input logic [T_W-1:0] dd);
    sig_v = sv;
    always_hi = hi;
    tdelta = td;
    ddelta = dd;
    v_q.delete();
    t_q.delete();
    w_q.delete();
    run = 1'b1;
  endtask

  task automatic wait_points(input int n, input int budget, input string tag);
    int c = 0;
    while (v_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 32'(v_q.size()), 32'(n));
  endtask

  task automatic wait_state(input state_e st, input int budget, input string tag);
    int c = 0;
    while (dut.state_q != st && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 32'(dut.state_q), 32'(st));
  endtask

  task automatic stop_run(input string tag);
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(tag, 32'(dut.state_q), 32'(IDLE));
    check({tag, "_dcode"}, 32'(d_code_o), 32'd0);
    check({tag, "_thr"}, 32'(threshold_o), 32'd0);
  endtask

  initial begin
    #2 arst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_thr", 32'(threshold_o), 32'd0);
    check("rst_wre", 32'(threshold_wre_o), 32'd0);
    check("rst_req", 32'(stb_req_o), 32'd0);
    check("rst_prdy", 32'(point_rdy_o), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Static 100, unit threshold step, delay step 300: t = 0, 300, 600, 900.
    start(V_W'(100), 1'b0, V_W'(1), T_W'(300));
    wait_points(4, 12000, "a_npts");
    wait_state(DONE, 200, "a_done");
    for (int i = 0; i < 4; i++) begin
      check("a_v", 32'(v_q[i]), 32'd100);
      check("a_t", 32'(t_q[i]), 32'(i * 300));
      check("a_wre", 32'(w_q[i]), 32'd102);
    end
    repeat (40) @(posedge clk);
    #1;
    check("a_hold_n", 32'(v_q.size()), 32'd4);
    check("a_hold_req", 32'(stb_req_o), 32'd0);
    check("a_hold_dcode", 32'(d_code_o), 32'd900);
    check("a_hold_pt", 32'(point_t_o), 32'd900);
    check("a_hold_pv", 32'(point_v_o), 32'd100);
    stop_run("a_idle");

    // Threshold step 16 on static 100: 96, eight DAC writes per point.
    start(V_W'(100), 1'b0, V_W'(16), T_W'(512));
    wait_points(2, 2000, "b_npts");
    wait_state(DONE, 200, "b_done");
    for (int i = 0; i < 2; i++) begin
      check("b_v", 32'(v_q[i]), 32'd96);
      check("b_t", 32'(t_q[i]), 32'(i * 512));
      check("b_wre", 32'(w_q[i]), 32'd8);
    end
    stop_run("b_idle");

    // Zero threshold step acts as 1; delay step 1023 lands exactly on the last code.
    start(V_W'(3), 1'b0, V_W'(0), T_W'(1023));
    wait_points(2, 1000, "z_npts");
    wait_state(DONE, 200, "z_done");
    check("z_v0", 32'(v_q[0]), 32'd3);
    check("z_v1", 32'(v_q[1]), 32'd3);
    check("z_t1", 32'(t_q[1]), 32'd1023);
    check("z_wre", 32'(w_q[0]), 32'd5);
    stop_run("z_idle");

    // Signal always above: saturate to all-ones; zero delay step sweeps all 1024 codes.
    start(V_W'(0), 1'b1, V_W'(16'h8000), T_W'(0));
    wait_points(1024, 60000, "c_npts");
    wait_state(DONE, 200, "c_done");
    for (int i = 0; i < 1024; i++) begin
      check("c_v", 32'(v_q[i]), 32'h0000_FFFF);
      check("c_t", 32'(t_q[i]), 32'(i));
    end
    check("c_wre", 32'(w_q[5]), 32'd2);
    check("c_last_t", 32'(point_t_o), 32'd1023);
    stop_run("c_idle");

    // Drop run_i mid-point: immediate abort, no further point.
    start(V_W'(0), 1'b1, V_W'(16'h8000), T_W'(1));
    wait_points(2, 300, "ab_npts");
    repeat (10) @(posedge clk);
    #1;
    run = 1'b0;
    @(posedge clk);
    #1;
    check("ab_state", 32'(dut.state_q), 32'(IDLE));
    check("ab_req", 32'(stb_req_o), 32'd0);
    check("ab_wre", 32'(threshold_wre_o), 32'd0);
    repeat (50) @(posedge clk);
    #1;
    check("ab_npts_after", 32'(v_q.size()), 32'd2);
    check("ab_dcode", 32'(d_code_o), 32'd0);
    check("ab_thr", 32'(threshold_o), 32'd0);

    // Asynchronous reset mid-sweep clears every output at once.
    start(V_W'(0), 1'b1, V_W'(16'h8000), T_W'(1));
    wait_points(3, 400, "r_npts");
    repeat (5) @(posedge clk);
    #3;
    arst = 1'b0;
    run = 1'b0;
    #1;
    check("r_thr", 32'(threshold_o), 32'd0);
    check("r_wre", 32'(threshold_wre_o), 32'd0);
    check("r_req", 32'(stb_req_o), 32'd0);
    check("r_dcode", 32'(d_code_o), 32'd0);
    check("r_prdy", 32'(point_rdy_o), 32'd0);
    check("r_pv", 32'(point_v_o), 32'd0);
    check("r_pt", 32'(point_t_o), 32'd0);
    check("r_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk);
    #1;
    arst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("r_idle", 32'(dut.state_q), 32'(IDLE));
    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
